// File: rtl/riscv_muldiv_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit with a start/busy/done handshake.
// Normal ops finish XLEN+1 cycles after start; divide-by-zero and signed overflow finish after 1 cycle.
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state, state_nxt;
  logic [2:0]          op;
  logic [XLEN-1:0]     divisor;
  logic [2*XLEN-1:0]   acc, acc_nxt, mul_nxt, div_nxt, prod_s;
  logic [CNT_W-1:0]    cnt;
  logic                neg_q, neg_r;

  logic                a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, ovf, special;
  logic [XLEN-1:0]     a_mag, b_mag, special_val, quo, rem, fin_val;
  logic [XLEN:0]       mul_sum, rem_sh, diff;
  logic                ge;

  // Operand decode on the live inputs; only consumed on the accepting edge.
  always_comb begin
    a_sgn       = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_sgn       = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg       = a_sgn && op_a[XLEN-1];
    b_neg       = b_sgn && op_b[XLEN-1];
    a_mag       = a_neg ? -op_a : op_a;
    b_mag       = b_neg ? -op_b : op_b;
    is_div      = funct3[2];
    div_zero    = is_div && (op_b == '0);
    ovf         = is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    special     = div_zero || ovf;
    special_val = '0;
    if (div_zero)  special_val = funct3[1] ? op_a : '1;
    else if (ovf)  special_val = funct3[1] ? '0 : op_a;
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, divisor};
    ge      = !diff[XLEN];
    div_nxt = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], ge};
    acc_nxt = op[2] ? div_nxt : mul_nxt;
  end

  always_comb begin
    prod_s = neg_q ? -acc_nxt : acc_nxt;
    quo    = acc_nxt[XLEN-1:0];
    rem    = acc_nxt[2*XLEN-1:XLEN];
    case (op)
      3'b000:         fin_val = prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fin_val = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: fin_val = neg_q ? -quo : quo;
      default:        fin_val = neg_r ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? FIN : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // Result is registered on the edge entering FIN so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (reset) begin
      op      <= '0;
      divisor <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op      <= funct3;
          divisor <= b_mag;
          acc     <= {{XLEN{1'b0}}, a_mag};
          neg_q   <= a_neg ^ b_neg;
          neg_r   <= a_neg;
          if (special) begin
            result <= special_val;
            cnt    <= '0;
          end else begin
            cnt    <= CNT_W'(XLEN);
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) result <= fin_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: a 32-bit and a 64-bit instance share stimulus and are
// compared every cycle against a wide-arithmetic reference model plus literal expectations.
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [63:0] a, b;
  logic        busy32, done32, busy64, done64;
  logic [31:0] res32;
  logic [63:0] res64;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(a[31:0]), .op_b(b[31:0]), .busy(busy32), .done(done32), .result(res32)
  );

  riscv_muldiv_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(a), .op_b(b), .busy(busy64), .done(done64), .result(res64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] width_mask(input int xl);
    return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit is_special(input int xl, input logic [2:0] f,
                                    input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, mn;
    m  = width_mask(xl);
    mn = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    return f[2] && (((b_in & m) == 0) || (!f[0] && ((a_in & m) == mn) && ((b_in & m) == m)));
  endfunction

  // Reference arithmetic on 130-bit signed integers.
  function automatic logic [63:0] model(input int xl, input logic [2:0] f,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, mn, x, y, r;
    logic signed [129:0] two, sx, sy, p, q, rm;
    logic [129:0] sh;
    m   = width_mask(xl);
    mn  = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    x   = a_in & m;
    y   = b_in & m;
    two = 130'sd1;
    two = two <<< xl;
    sx  = $signed({66'd0, x});
    sy  = $signed({66'd0, y});
    if ((f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110}) && ((x & mn) != 0)) sx = sx - two;
    if ((f inside {3'b000, 3'b001, 3'b100, 3'b110}) && ((y & mn) != 0))         sy = sy - two;
    if (!f[2]) begin
      p  = sx * sy;
      sh = (f == 3'b000) ? p : (p >> xl);
      r  = sh[63:0];
    end else if (y == 0) begin
      r = f[1] ? x : m;
    end else begin
      q  = sx / sy;
      rm = sx % sy;
      r  = f[1] ? rm[63:0] : q[63:0];
    end
    return r & m;
  endfunction

  // Cycle-level expectation: m_left = busy cycles remaining; done on the last one.
  int          m_left [2] = '{0, 0};
  logic [63:0] m_val  [2] = '{64'd0, 64'd0};
  logic [63:0] m_res  [2] = '{64'd0, 64'd0};

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int xl;
      xl = (i == 0) ? 32 : 64;
      if (reset) begin
        m_left[i] = 0;
        m_res[i]  = 64'd0;
      end else if (m_left[i] == 0) begin
        if (start) begin
          m_val[i]  = model(xl, funct3, a, b);
          m_left[i] = is_special(xl, funct3, a, b) ? 1 : xl + 1;
          if (m_left[i] == 1) m_res[i] = m_val[i];
        end
      end else begin
        m_left[i]--;
        if (m_left[i] == 1) m_res[i] = m_val[i];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy32",   {63'd0, busy32}, {63'd0, m_left[0] != 0});
      chk("done32",   {63'd0, done32}, {63'd0, m_left[0] == 1});
      chk("result32", {32'd0, res32},  m_res[0]);
      chk("busy64",   {63'd0, busy64}, {63'd0, m_left[1] != 0});
      chk("done64",   {63'd0, done64}, {63'd0, m_left[1] == 1});
      chk("result64", res64,           m_res[1]);
    end
  end

  int t0;

  task automatic issue(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    start = 1'b1; funct3 = f; a = x; b = y;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit wide, output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      if (wide ? done64 : done32) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300 && (busy32 || busy64); k++) @(negedge clk);
    if (k >= 300) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x, y, e;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int lat, n_done;
    int dcyc [$];
    vecs = '{
      '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
      '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
      '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
      '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
      '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33},
      '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33},
      '{3'b101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 33},
      '{3'b111, 32'hFFFF_FFF9, 32'h0000_0010, 32'h0000_0009, 33},
      '{3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1},
      '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1},
      '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1},
      '{3'b000, 32'h0000_3039, 32'h0000_0000, 32'h0000_0000, 33},
      '{3'b101, 32'hFFFF_FFFF, 32'h0000_0003, 32'h5555_5555, 33},
      '{3'b110, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0001, 33},
      '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33}
    };

    reset = 1'b1; start = 1'b0; funct3 = 3'b000; a = 64'd0; b = 64'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy",   {63'd0, busy32 | busy64}, 64'd0);
    chk("reset_done",   {63'd0, done32 | done64}, 64'd0);
    chk("reset_result", {32'd0, res32} | res64,   64'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].f, {32'd0, vecs[i].x}, {32'd0, vecs[i].y});
      wait_done(1'b0, lat);
      chk($sformatf("latency_v%0d", i), lat, vecs[i].lat);
      chk($sformatf("value_v%0d", i), {32'd0, res32}, {32'd0, vecs[i].e});
      wait_idle();
    end

    // A second start during a multiply must not disturb it.
    issue(3'b000, 64'd7, 64'h0000_0000_FFFF_FFFD);
    repeat (3) @(negedge clk);
    start = 1'b1; funct3 = 3'b100; a = 64'd100; b = 64'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, lat);
    chk("ignored_start_lat", lat, 33);
    chk("ignored_start_val", {32'd0, res32}, 64'hFFFF_FFEB);
    wait_idle();

    // Start held high: back-to-back operations.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 64'd3; b = 64'd5;
    t0 = cyc;
    while (cyc - t0 < 70) begin
      @(negedge clk);
      if (done32) dcyc.push_back(cyc - t0);
    end
    start = 1'b0;
    chk("b2b_count", dcyc.size(), 2);
    if (dcyc.size() == 2) begin
      chk("b2b_first",  dcyc[0], 33);
      chk("b2b_second", dcyc[1], 67);
    end
    wait_idle();

    // Reset in the middle of a divide.
    issue(3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    while (cyc - t0 < 10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy",   {63'd0, busy32 | busy64}, 64'd0);
    chk("abort_done",   {63'd0, done32 | done64}, 64'd0);
    chk("abort_result", {32'd0, res32} | res64,   64'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32 || done64) n_done++;
    end
    chk("abort_no_done", n_done, 0);

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; funct3 = 3'b000; a = 64'd2; b = 64'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_start_busy", {63'd0, busy32 | busy64}, 64'd0);

    // 64-bit high-half multiply.
    issue(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(1'b1, lat);
    chk("x64_latency", lat, 65);
    chk("x64_mulhu", res64, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
